mems_dac_spi: RTL
=================

# mems_dac_spi

Serial back end for the MEMS mirror drive path.
- Steps the 16-bit sample address consumed by the ROM/channel-mapping stage.
- Waits for that stage's registered 24-bit DAC word to settle, then shifts it out MSB-first as one 24-bit SPI frame (SYNC/SCLK/DIN) to a quad 16-bit DAC.
- One instance drives one DAC; the top level instantiates one per mirror axis group.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period (≥1).
- SETTLE_CYCLES, 12: clk cycles between an addr change and latching `data` (covers the upstream three-slot round-robin plus its output register).
- GAP_CYCLES, 6: minimum clk cycles sync_n stays high between frames (≥1).
- ADDR_MAX, 16'd8191: last address of the pattern.

Ports (reset is asynchronous, active-low):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins streaming from the current addr when idle.
- stop  in  1  single-cycle pulse; finish the current frame, then go idle.
- data  in  24  DAC word for the current addr, from the upstream stage.
- addr  out  16  sample address driven to the upstream stage.
- sclk  out  1  SPI clock, idles high.
- sync_n  out  1  frame strobe, active low.
- din  out  1  serial data, MSB first.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when sync_n rises at frame end.

## Operation
- States: IDLE, SETTLE, LATCH, SHIFT, GAP.
- IDLE:
  - On start, go to SETTLE.
  - stop in IDLE is ignored.
- SETTLE:
  - Counter runs 0..SETTLE_CYCLES-1.
  - Go to LATCH on the last count.
- LATCH:
  - Capture `data` into a 24-bit shift register.
  - Set bit counter to 23.
  - Drive sync_n low with din = data[23].
  - Go to SHIFT.
- SHIFT:
  - Each bit is CLK_DIV cycles with sclk high, then CLK_DIV cycles with sclk low. The DAC samples on the falling edge.
  - At the end of each low phase, sclk returns high. If bits remain, shift left and present the next bit on din in that same cycle.
  - After bit 0's low phase, sclk goes high and sync_n goes high in the same cycle. Pulse frame_done and go to GAP.
- GAP:
  - Hold sync_n and sclk high for GAP_CYCLES.
  - On exit, advance addr:
    - addr < ADDR_MAX: addr+1.
    - addr == ADDR_MAX: wrap to 2. Addresses 0 (soft reset) and 1 (Vref) are sent once per start-from-reset only.
  - If a stop was latched during the frame, go to IDLE; otherwise go to SETTLE.
- stop:
  - Captured in a sticky flag while busy.
  - Cleared on entry to IDLE.
  - Never truncates a frame.
- start while busy is ignored.
- start and stop in the same IDLE cycle: start wins; the stop flag is set, so exactly one frame is sent.
- addr changes only on GAP exit and on reset; it is stable throughout SETTLE/LATCH/SHIFT.
- Asserting reset mid-frame aborts immediately: outputs take reset values and addr returns to 0.

## Timing
- Reset values: addr=0, sclk=1, sync_n=1, din=0, busy=0, frame_done=0, state IDLE.
- start at cycle t: busy=1 at t+1; sync_n falls at t+1+SETTLE_CYCLES+1.
- sync_n low for exactly 48·CLK_DIV cycles; 24 falling sclk edges per frame.
- din is stable ≥CLK_DIV cycles before and after every falling sclk edge.
- Frame period = 1 + SETTLE_CYCLES + 48·CLK_DIV + GAP_CYCLES cycles. Defaults: 1+12+192+6 = 211.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- MEMS_SPI_LOOP_EN:
  - Defined: at ADDR_MAX, addr wraps to 2 and streaming continues until stop.
  - Undefined: after the frame at ADDR_MAX, the block goes to IDLE with addr held at ADDR_MAX. A later start resends ADDR_MAX only after wrapping to 2, i.e. the next frame uses addr 2.

## Test plan
- Reset then start, data=24'h280001 at addr 0 -> sync_n low 192 cycles, 24 falling edges, captured word 0x280001, frame_done pulses once, addr→1.
- Consecutive frames, data=addr-dependent pattern, CLK_DIV=1 -> sync_n high exactly GAP_CYCLES between frames, period 1+12+48+6=67 cycles.
- With MEMS_SPI_LOOP_EN, ADDR_MAX=4 -> addr sequence 0,1,2,3,4,2,3,4,…
- Without MEMS_SPI_LOOP_EN, ADDR_MAX=4 -> frames for addr 0–4, then busy=0 and addr=4.
- stop pulsed at the 10th falling edge of a frame -> frame completes all 24 bits, then IDLE; no further sync_n fall.
- rst asserted during SHIFT bit 12 -> same cycle: sync_n=1, sclk=1, din=0, busy=0, addr=0; DAC sees an incomplete frame (<24 edges).

Source files
------------

// File: rtl/mems_dac_spi.sv
`timescale 1ns/1ps
// Serial back end for the MEMS mirror DAC: steps the sample address, waits for the
// upstream word to settle, then shifts it out as a 24-bit SPI frame. Macro: MEMS_SPI_LOOP_EN.
module mems_dac_spi #(
  parameter int          CLK_DIV       = 4,
  parameter int          SETTLE_CYCLES = 12,
  parameter int          GAP_CYCLES    = 6,
  parameter logic [15:0] ADDR_MAX      = 16'd8191
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [23:0] data,
  output logic [15:0] addr,
  output logic        sclk,
  output logic        sync_n,
  output logic        din,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {IDLE, SETTLE, LATCH, SHIFT, GAP} state_t;

  state_t      state, state_next;
  logic [15:0] cnt;
  logic [4:0]  bit_cnt;
  logic [23:0] sr;
  logic        stop_flag;
  logic        wrap_pending;
  logic        cnt_last;
  logic        at_max;
  logic        pattern_end;

  assign at_max = (addr == ADDR_MAX);
  assign din    = sr[23];

`ifdef MEMS_SPI_LOOP_EN
  assign pattern_end = 1'b0;
`else
  assign pattern_end = at_max;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_next = state;
    cnt_last   = 1'b0;
    unique case (state)
      IDLE:   if (start) state_next = SETTLE;
      SETTLE: begin
        cnt_last = (cnt == 16'(SETTLE_CYCLES - 1));
        if (cnt_last) state_next = LATCH;
      end
      LATCH:  state_next = SHIFT;
      SHIFT: begin
        cnt_last = (cnt == 16'(CLK_DIV - 1));
        if (cnt_last && !sclk && bit_cnt == 5'd0) state_next = GAP;
      end
      GAP: begin
        cnt_last = (cnt == 16'(GAP_CYCLES - 1));
        if (cnt_last) state_next = (stop_flag || pattern_end) ? IDLE : SETTLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      bit_cnt      <= '0;
      sr           <= '0;
      addr         <= '0;
      sclk         <= 1'b1;
      sync_n       <= 1'b1;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      stop_flag    <= 1'b0;
      wrap_pending <= 1'b0;
    end else begin
      busy       <= (state_next != IDLE);
      frame_done <= 1'b0;

      // Entering IDLE wins over a coincident stop; start+stop in IDLE leaves the flag set.
      if (state_next == IDLE) stop_flag <= 1'b0;
      else if (stop)          stop_flag <= 1'b1;

      if (state == IDLE || cnt_last || state_next != state) cnt <= '0;
      else                                                   cnt <= cnt + 16'd1;

      unique case (state)
        IDLE: begin
          if (start && wrap_pending) begin
            addr         <= 16'd2;
            wrap_pending <= 1'b0;
          end
        end
        LATCH: begin
          sr      <= data;
          bit_cnt <= 5'd23;
          sync_n  <= 1'b0;
        end
        SHIFT: begin
          if (cnt_last) begin
            if (sclk) begin
              sclk <= 1'b0;
            end else begin
              sclk <= 1'b1;
              if (bit_cnt == 5'd0) begin
                sync_n     <= 1'b1;
                frame_done <= 1'b1;
                sr         <= '0;
              end else begin
                bit_cnt <= bit_cnt - 5'd1;
                sr      <= {sr[22:0], 1'b0};
              end
            end
          end
        end
        GAP: begin
          // Addresses 0 and 1 are one-shot set-up words; the pattern loops over 2..ADDR_MAX.
          if (cnt_last) begin
            if (!at_max)          addr         <= addr + 16'd1;
            else if (pattern_end) wrap_pending <= 1'b1;
            else                  addr         <= 16'd2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
